hazard_ctrl_mc: RTL and testbench

- Parametrised successor to the 5-stage hazard/forwarding logic of the 16-bit RISC pipeline.
- Tracks its own EX/MEM/WB destination tags, so the datapath only supplies decode-stage fields.
- Generates per-source forwarding selects, load-use and multi-cycle-EX stalls, bubble insertion, and store-data mem-to-mem forwarding.
- Sits beside the decode stage and drives PC/IF-ID enables and the ID/EX bubble.

---
 rtl/hazard_ctrl_mc.sv | 115 +++++++++++
 tb/tb_hazard_ctrl_mc.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl_mc.sv
// Hazard/forwarding controller for the 5-stage pipeline. It keeps its own EX/MEM/WB
// destination tags and drives operand forwarding, stalls, bubbles and store-data forwarding.
module hazard_ctrl_mc #(
  parameter int REG_AW   = 3,
  parameter int NUM_SRC  = 2,
  parameter int MC_LAT   = 4,
  parameter int ZERO_REG = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      id_valid,
  input  logic [NUM_SRC*REG_AW-1:0] id_rs,
  input  logic [NUM_SRC-1:0]        id_src_used,
  input  logic [REG_AW-1:0]         id_rd,
  input  logic                      id_regwr,
  input  logic                      id_memrd,
  input  logic                      id_memwr,
  input  logic                      id_mc,
  input  logic                      flush,
  output logic [2*NUM_SRC-1:0]      fwd_sel,
  output logic                      stall,
  output logic                      bubble_e,
  output logic                      fwd_me_e,
  output logic                      ex_busy
);

  localparam int CW = (MC_LAT > 2) ? $clog2(MC_LAT) : 1;
  localparam logic [CW-1:0] MC_LOAD = CW'(MC_LAT - 1);
  localparam logic ZR = (ZERO_REG != 0);
  localparam logic [NUM_SRC-1:0] LAST_MASK = NUM_SRC'(1) << (NUM_SRC - 1);

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              regwr;
    logic              memrd;
    logic              mc;
  } tag_t;

  tag_t          ex_q, mem_q, wb_q;
  tag_t          id_tag;
  logic [CW-1:0] cnt_q;

  logic               idv;
  logic [NUM_SRC-1:0] hit_ex;
  logic               any_ex;
  logic               other_ex;
  logic               me_next;
  logic               ld_hz;
  logic               mc_hz;
  logic               advance;

  function automatic logic slot_hit(input tag_t t, input logic [REG_AW-1:0] rs);
    return t.valid & t.regwr & (t.rd == rs);
  endfunction

  assign idv    = id_valid & ~flush;
  assign id_tag = {1'b1, id_rd, id_regwr, id_memrd, id_mc};

  // Youngest producer wins: EX before MEM before WB.
  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
    logic [REG_AW-1:0] rs_g;
    logic              elig_g;
    logic              hit_mem_g;
    logic              hit_wb_g;

    assign rs_g       = id_rs[gi*REG_AW +: REG_AW];
    assign elig_g     = idv & id_src_used[gi] & ~(ZR & (rs_g == '0));
    assign hit_ex[gi] = elig_g & slot_hit(ex_q, rs_g);
    assign hit_mem_g  = elig_g & slot_hit(mem_q, rs_g);
    assign hit_wb_g   = elig_g & slot_hit(wb_q, rs_g);

    always_comb begin
      fwd_sel[2*gi +: 2] = 2'b00;
      if (hit_ex[gi])     fwd_sel[2*gi +: 2] = 2'b01;
      else if (hit_mem_g) fwd_sel[2*gi +: 2] = 2'b10;
      else if (hit_wb_g)  fwd_sel[2*gi +: 2] = 2'b11;
    end
  end

  assign any_ex   = |hit_ex;
  assign other_ex = |(hit_ex & ~LAST_MASK);

  // A store whose only EX dependency is its data operand takes the load data in MEM instead.
  assign me_next  = ex_q.memrd & id_memwr & hit_ex[NUM_SRC-1] & ~other_ex;
  assign ld_hz    = any_ex & ex_q.memrd & ~me_next;
  assign ex_busy  = (cnt_q != '0);
  assign mc_hz    = any_ex & ex_busy;
  assign stall    = ex_busy | ld_hz | mc_hz;
  assign bubble_e = (ld_hz | mc_hz) & ~ex_busy;
  assign advance  = idv & ~stall;

  always_ff @(posedge clk) begin
    if (!reset) begin
      ex_q     <= '0;
      mem_q    <= '0;
      wb_q     <= '0;
      cnt_q    <= '0;
      fwd_me_e <= 1'b0;
    end else if (ex_busy) begin
      // Multi-cycle op parks in EX; MEM drains and receives a bubble.
      mem_q    <= '0;
      wb_q     <= mem_q;
      cnt_q    <= cnt_q - CW'(1);
      fwd_me_e <= 1'b0;
    end else begin
      wb_q     <= mem_q;
      mem_q    <= ex_q;
      ex_q     <= advance ? id_tag : '0;
      cnt_q    <= (advance & id_mc) ? MC_LOAD : '0;
      fwd_me_e <= advance & me_next;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl_mc.sv
// Scoreboard bench for hazard_ctrl_mc: a small pipeline-tag model pushes expected outputs
// per driven cycle and they are popped and compared when the outputs are sampled.
module tb_hazard_ctrl_mc;

  localparam int AW  = 3;
  localparam int NS  = 2;
  localparam int LAT = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          id_valid;
  logic [NS*AW-1:0] id_rs;
  logic [NS-1:0] id_src_used;
  logic [AW-1:0] id_rd;
  logic          id_regwr, id_memrd, id_memwr, id_mc, flush;
  logic [2*NS-1:0] fwd_sel;
  logic          stall, bubble_e, fwd_me_e, ex_busy;

  always #5 clk = ~clk;

  hazard_ctrl_mc #(.REG_AW(AW), .NUM_SRC(NS), .MC_LAT(LAT), .ZERO_REG(1)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs),
    .id_src_used(id_src_used), .id_rd(id_rd), .id_regwr(id_regwr),
    .id_memrd(id_memrd), .id_memwr(id_memwr), .id_mc(id_mc), .flush(flush),
    .fwd_sel(fwd_sel), .stall(stall), .bubble_e(bubble_e),
    .fwd_me_e(fwd_me_e), .ex_busy(ex_busy)
  );

  typedef struct {
    logic [3:0] sel;
    logic       stl;
    logic       bub;
    logic       busy;
    logic       me;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_txn = 0;

  // Model slots: index 0 = EX, 1 = MEM, 2 = WB.
  bit       mv[3];
  bit [2:0] mrd[3];
  bit       mwr[3];
  bit       mld[3];
  bit       mmc[3];
  int       mcnt = 0;
  bit       mme  = 1'b0;

  task automatic check_val(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL txn %0d %s: got %0h expected %0h", n_txn, tag, got, exp);
    end
  endtask

  task automatic cyc(input bit rst, input bit v, input bit [2:0] r0, input bit [2:0] r1,
                     input bit [1:0] used, input bit [2:0] rd, input bit wr, input bit ld,
                     input bit st, input bit mc, input bit fl);
    bit       idv, anyex, m2m, ldh, mch, busy, stl, adv;
    bit [2:0] rs[2];
    int       k[2];
    exp_t     e, g;

    reset = rst; id_valid = v; id_rs = {r1, r0}; id_src_used = used; id_rd = rd;
    id_regwr = wr; id_memrd = ld; id_memwr = st; id_mc = mc; flush = fl;

    idv = v & ~fl;
    rs[0] = r0;
    rs[1] = r1;
    for (int i = 0; i < 2; i++) begin
      k[i] = 0;
      if (idv && used[i] && rs[i] != 3'd0)
        for (int s = 0; s < 3; s++)
          if (k[i] == 0 && mv[s] && mwr[s] && mrd[s] == rs[i]) k[i] = s + 1;
    end
    anyex = (k[0] == 1) || (k[1] == 1);
    m2m   = st && mld[0] && (k[1] == 1) && (k[0] != 1);
    ldh   = anyex && mld[0] && !m2m;
    busy  = (mcnt != 0);
    mch   = anyex && busy;
    stl   = busy || ldh || mch;
    e.sel  = {2'(k[1]), 2'(k[0])};
    e.stl  = stl;
    e.bub  = (ldh || mch) && !busy;
    e.busy = busy;
    e.me   = mme;
    sbq.push_back(e);

    @(negedge clk);
    g = sbq.pop_front();
    $display("txn %0d rst=%0b v=%0b rs=%0d,%0d rd=%0d fl=%0b | sel=%b stall=%0b bub=%0b busy=%0b me=%0b",
             n_txn, rst, v, r0, r1, rd, fl, fwd_sel, stall, bubble_e, ex_busy, fwd_me_e);
    check_val("fwd_sel",  fwd_sel,  g.sel);
    check_val("stall",    {3'b0, stall},    {3'b0, g.stl});
    check_val("bubble_e", {3'b0, bubble_e}, {3'b0, g.bub});
    check_val("ex_busy",  {3'b0, ex_busy},  {3'b0, g.busy});
    check_val("fwd_me_e", {3'b0, fwd_me_e}, {3'b0, g.me});
    n_txn++;

    @(posedge clk);
    if (!rst) begin
      for (int s = 0; s < 3; s++) mv[s] = 1'b0;
      mcnt = 0;
      mme  = 1'b0;
    end else if (busy) begin
      mv[2] = mv[1]; mrd[2] = mrd[1]; mwr[2] = mwr[1]; mld[2] = mld[1]; mmc[2] = mmc[1];
      mv[1] = 1'b0;
      mcnt  = mcnt - 1;
      mme   = 1'b0;
    end else begin
      adv = idv && !stl;
      mv[2] = mv[1]; mrd[2] = mrd[1]; mwr[2] = mwr[1]; mld[2] = mld[1]; mmc[2] = mmc[1];
      mv[1] = mv[0]; mrd[1] = mrd[0]; mwr[1] = mwr[0]; mld[1] = mld[0]; mmc[1] = mmc[0];
      mv[0] = adv; mrd[0] = rd; mwr[0] = wr; mld[0] = ld; mmc[0] = mc;
      mcnt  = (adv && mc) ? LAT - 1 : 0;
      mme   = adv && m2m;
    end
    #1;
  endtask

  task automatic idle();
    cyc(1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    bit rr, ll;
    for (int s = 0; s < 3; s++) begin
      mv[s] = 1'b0; mrd[s] = '0; mwr[s] = 1'b0; mld[s] = 1'b0; mmc[s] = 1'b0;
    end
    reset = 1'b0; id_valid = 1'b0; id_rs = '0; id_src_used = '0; id_rd = '0;
    id_regwr = 1'b0; id_memrd = 1'b0; id_memwr = 1'b0; id_mc = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    idle();

    // Back-to-back ALU: EX, then MEM, then WB forwarding of r3
    cyc(1, 1, 1, 2, 2'b11, 3, 1, 0, 0, 0, 0);
    cyc(1, 1, 3, 1, 2'b11, 5, 1, 0, 0, 0, 0);
    cyc(1, 1, 3, 2, 2'b11, 6, 1, 0, 0, 0, 0);
    cyc(1, 1, 3, 2, 2'b11, 7, 1, 0, 0, 0, 0);
    idle(); idle(); idle();

    // Load-use on src1, retry forwards from MEM
    cyc(1, 1, 1, 0, 2'b01, 2, 1, 1, 0, 0, 0);
    cyc(1, 1, 1, 2, 2'b11, 4, 1, 0, 0, 0, 0);
    cyc(1, 1, 1, 2, 2'b11, 4, 1, 0, 0, 0, 0);
    idle(); idle(); idle();

    // Mem-to-mem store data forwarding, then base-register conflict
    cyc(1, 1, 1, 0, 2'b01, 4, 1, 1, 0, 0, 0);
    cyc(1, 1, 1, 4, 2'b11, 0, 0, 0, 1, 0, 0);
    idle();
    cyc(1, 1, 1, 0, 2'b01, 4, 1, 1, 0, 0, 0);
    cyc(1, 1, 4, 4, 2'b11, 0, 0, 0, 1, 0, 0);
    cyc(1, 1, 4, 4, 2'b11, 0, 0, 0, 1, 0, 0);
    idle(); idle(); idle();

    // Multi-cycle mul with a dependent op waiting in decode
    cyc(1, 1, 1, 2, 2'b11, 5, 1, 0, 0, 1, 0);
    repeat (4) cyc(1, 1, 5, 1, 2'b11, 6, 1, 0, 0, 0, 0);
    idle();
    cyc(1, 1, 1, 2, 2'b11, 5, 1, 0, 0, 1, 0);
    repeat (4) idle();
    cyc(1, 1, 5, 0, 2'b01, 7, 1, 0, 0, 0, 0);
    idle(); idle(); idle();

    // Zero register is never forwarded; flush overrides a load-use hazard
    cyc(1, 1, 1, 2, 2'b11, 0, 1, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 2'b11, 3, 1, 0, 0, 0, 0);
    idle(); idle(); idle();
    cyc(1, 1, 1, 0, 2'b01, 2, 1, 1, 0, 0, 0);
    cyc(1, 1, 1, 2, 2'b11, 4, 1, 0, 0, 0, 1);
    cyc(1, 1, 2, 4, 2'b11, 5, 1, 0, 0, 0, 0);
    idle(); idle(); idle();

    // Reset on the second busy cycle of a mul
    cyc(1, 1, 1, 2, 2'b11, 6, 1, 0, 0, 1, 0);
    idle();
    cyc(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 6, 6, 2'b11, 1, 1, 0, 0, 0, 0);
    idle(); idle();

    // Random traffic over a small register range to provoke hazards
    for (int n = 0; n < 300; n++) begin
      rr = ($urandom_range(0, 59) != 0);
      ll = ($urandom_range(0, 3) == 0);
      cyc(rr, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)),
          2'($urandom_range(0, 3)), 3'($urandom_range(0, 3)),
          ll | 1'($urandom_range(0, 1)), ll, 1'($urandom_range(0, 2) == 0),
          1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 7) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
